// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller:
// stall-vector encodings, controller state encoding and the load-use test.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int STALL_W    = 6;

    // Stall vector bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold.
    localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MULTI    = 6'b001111;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        CTRL_RUN     = 1'b0,
        CTRL_MC_BUSY = 1'b1
    } ctrl_state_e;

    // True when the load in EX produces a register that ID is about to read.
    // Register $0 is hard-wired to zero, so it can never be a real dependency.
    function automatic logic load_use_hit(
        input logic                  ex_is_load,
        input logic                  ex_wreg,
        input logic [REG_ADDR_W-1:0] ex_wd,
        input logic                  rd1,
        input logic [REG_ADDR_W-1:0] addr1,
        input logic                  rd2,
        input logic [REG_ADDR_W-1:0] addr2
    );
        logic src_match;
        src_match = (rd1 && (addr1 == ex_wd)) || (rd2 && (addr2 == ex_wd));
        return ex_is_load && ex_wreg && (ex_wd != REG_ZERO) && src_match;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Decides stall,
// bubble and flush in the same cycle from the current hazards, tracks
// multi-cycle EX occupancy and counts front-end stall cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MC_LAT = 8,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg1_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
    input  logic                  id_reg2_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_wreg_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic                  ex_mc_req_i,
    input  logic                  flush_i,
    output logic [STALL_W-1:0]    stall_o,
    output logic                  id_bubble_o,
    output logic                  flush_o,
    output logic                  ex_mc_done_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    // The request cycle itself is the first of MC_LAT occupancy cycles, so the
    // down-counter starts one short and the done pulse fires when it reads 1.
    localparam logic [7:0]       MC_LOAD  = 8'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    ctrl_state_e          state_r;
    ctrl_state_e          state_nxt_s;
    logic [7:0]           mc_cnt_r;
    logic [7:0]           mc_cnt_nxt_s;
    logic [CNT_W-1:0]     stall_cnt_r;
    logic                 lu_s;
    logic [STALL_W-1:0]   stall_s;
    logic                 bubble_s;
    logic                 flush_s;
    logic                 done_s;

    // Same-cycle hazard decision and next-state selection; flush beats
    // multi-cycle, which beats load-use. Outputs are forced low in reset.
    always_comb begin
        stall_s      = STALL_NONE;
        bubble_s     = 1'b0;
        flush_s      = 1'b0;
        done_s       = 1'b0;
        state_nxt_s  = state_r;
        mc_cnt_nxt_s = mc_cnt_r;
        lu_s = load_use_hit(ex_is_load_i, ex_wreg_i, ex_wd_i,
                            id_reg1_read_i, id_reg1_addr_i,
                            id_reg2_read_i, id_reg2_addr_i);
        if (!rst) begin
            state_nxt_s  = CTRL_RUN;
            mc_cnt_nxt_s = 8'd0;
        end else begin
            case (state_r)
                CTRL_RUN: begin
                    if (flush_i) begin
                        flush_s = 1'b1;
                    end else if (ex_mc_req_i) begin
                        // A load cannot sit in EX alongside a mul/div, so lu is moot.
                        stall_s      = STALL_MULTI;
                        mc_cnt_nxt_s = MC_LOAD;
                        state_nxt_s  = CTRL_MC_BUSY;
                    end else if (lu_s) begin
                        // One cycle is enough: the load moves to MEM and forwards.
                        stall_s  = STALL_LOAD_USE;
                        bubble_s = 1'b1;
                    end else begin
                        stall_s = STALL_NONE;
                    end
                end
                CTRL_MC_BUSY: begin
                    if (flush_i) begin
                        flush_s      = 1'b1;
                        mc_cnt_nxt_s = 8'd0;
                        state_nxt_s  = CTRL_RUN;
                    end else if (mc_cnt_r == 8'd1) begin
                        done_s       = 1'b1;
                        mc_cnt_nxt_s = 8'd0;
                        state_nxt_s  = CTRL_RUN;
                    end else begin
                        stall_s      = STALL_MULTI;
                        mc_cnt_nxt_s = mc_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_nxt_s  = CTRL_RUN;
                    mc_cnt_nxt_s = 8'd0;
                end
            endcase
        end
    end

    // State, occupancy counter and saturating stall-cycle counter update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= CTRL_RUN;
            mc_cnt_r    <= 8'd0;
            stall_cnt_r <= CNT_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            mc_cnt_r <= mc_cnt_nxt_s;
            if (stall_s[0] && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stall_o      = stall_s;
    assign id_bubble_o  = bubble_s;
    assign flush_o      = flush_s;
    assign ex_mc_done_o = done_s;
    assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all compared each cycle against a timeline-based model.
module tb_pipe_hazard_ctrl;

    localparam int MC_LAT  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_reg1_read_i, id_reg2_read_i;
    logic [4:0]       id_reg1_addr_i, id_reg2_addr_i;
    logic             ex_is_load_i, ex_wreg_i, ex_mc_req_i, flush_i;
    logic [4:0]       ex_wd_i;
    logic [5:0]       stall_o;
    logic             id_bubble_o, flush_o, ex_mc_done_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: an op in flight is remembered by its start cycle.
    bit busy_m = 1'b0;
    int t0_m   = 0;
    int cyc_m  = 0;
    int cnt_m  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
        .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
        .ex_is_load_i(ex_is_load_i), .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
        .ex_mc_req_i(ex_mc_req_i), .flush_i(flush_i),
        .stall_o(stall_o), .id_bubble_o(id_bubble_o), .flush_o(flush_o),
        .ex_mc_done_o(ex_mc_done_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic r, input logic mc, input logic fl,
                        input logic ld, input logic wr, input logic [4:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2);
        logic [5:0] e_stall;
        logic       e_bub, e_fl, e_done, lu;
        bit         nb;
        int         nt0, ncnt;
        @(negedge clk);
        rst = r; ex_mc_req_i = mc; flush_i = fl;
        ex_is_load_i = ld; ex_wreg_i = wr; ex_wd_i = wd;
        id_reg1_read_i = r1; id_reg1_addr_i = a1;
        id_reg2_read_i = r2; id_reg2_addr_i = a2;
        #1;
        lu = ld && wr && (wd != 5'd0) && ((r1 && a1 == wd) || (r2 && a2 == wd));
        e_stall = 6'b000000; e_bub = 1'b0; e_fl = 1'b0; e_done = 1'b0;
        nb = busy_m; nt0 = t0_m; ncnt = cnt_m;
        if (!r) begin
            nb = 1'b0; ncnt = 0;
        end else if (!busy_m) begin
            if (fl) e_fl = 1'b1;
            else if (mc) begin e_stall = 6'b001111; nb = 1'b1; nt0 = cyc_m; end
            else if (lu) begin e_stall = 6'b000111; e_bub = 1'b1; end
        end else begin
            if (fl) begin e_fl = 1'b1; nb = 1'b0; end
            else if (cyc_m - t0_m == MC_LAT - 1) begin e_done = 1'b1; nb = 1'b0; end
            else e_stall = 6'b001111;
        end
        if (r && e_stall[0] && ncnt < CNT_SAT) ncnt++;
        check("stall",  32'(stall_o),      32'(e_stall));
        check("bubble", 32'(id_bubble_o),  32'(e_bub));
        check("flush",  32'(flush_o),      32'(e_fl));
        check("done",   32'(ex_mc_done_o), 32'(e_done));
        check("cnt",    32'(stall_cnt_o),  32'(cnt_m));
        @(posedge clk);
        busy_m = nb; t0_m = nt0; cnt_m = ncnt; cyc_m++;
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic mc(input logic r, input logic fl);
        step(r, 1'b1, fl, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // Counter value right after the last edge, against a fixed expectation.
    task automatic check_cnt(input string tag, input int exp);
        #2;
        check(tag, 32'(stall_cnt_o), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; ex_mc_req_i = 1'b0; flush_i = 1'b0;
        ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = 5'd0;
        id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
        id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;

        // Reset with live requests: every output must stay low.
        mc(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        check_cnt("reset_cnt", 0);

        // Load-use on source 2 stalls one cycle only.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        idle(1'b1);
        check_cnt("lu_cnt", 1);

        // Register $0 never hazards.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        check_cnt("zero_cnt", 1);

        // Full multi-cycle op: 7 stall cycles then a done pulse.
        idle(1'b0);
        for (int i = 0; i < MC_LAT; i++) mc(1'b1, 1'b0);
        idle(1'b1);
        check_cnt("mc_cnt", 7);

        // Flush in the middle of an op aborts it without a done pulse.
        idle(1'b0);
        for (int i = 0; i < 3; i++) mc(1'b1, 1'b0);
        mc(1'b1, 1'b1);
        idle(1'b1);
        check_cnt("flush_cnt", 3);

        // Reset mid-op, then a fresh request runs the full latency.
        idle(1'b0);
        mc(1'b1, 1'b0);
        mc(1'b1, 1'b0);
        mc(1'b0, 1'b0);
        for (int i = 0; i < MC_LAT; i++) mc(1'b1, 1'b0);
        idle(1'b1);
        check_cnt("rst_mid_cnt", 7);

        // Request held across done restarts immediately.
        idle(1'b0);
        for (int i = 0; i < 2 * MC_LAT; i++) mc(1'b1, 1'b0);
        check_cnt("b2b_cnt", 14);

        // Flush outranks load-use; then load-use saturates the counter.
        idle(1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
        check_cnt("sat_cnt", CNT_SAT);

        // Random traffic with small address space to make hazards common.
        idle(1'b0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Detects load-use hazards between the ID and EX stages. Holds the pipeline while a multi-cycle EX operation (iterative mul/div) occupies EX. Converts flush requests into pipeline flushes.
- Drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Counts stall cycles for performance monitoring.

Parameters:
- MC_LAT, 8: total EX occupancy in cycles of a multi-cycle op; legal range 2..255.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; rst==0 at a clk edge resets all state.
- id_reg1_read_i  input  1  ID reads source operand 1 from the register file.
- id_reg1_addr_i  input  5  ID source register 1 address.
- id_reg2_read_i  input  1  ID reads source operand 2 from the register file.
- id_reg2_addr_i  input  5  ID source register 2 address.
- ex_is_load_i  input  1  instruction in EX is a load.
- ex_wreg_i  input  1  instruction in EX writes a register.
- ex_wd_i  input  5  EX destination register.
- ex_mc_req_i  input  1  instruction in EX is a multi-cycle op; level, held while EX is stalled.
- flush_i  input  1  flush request (exception/redirect).
- stall_o  output  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- id_bubble_o  output  1  insert NOP into the ID/EX register this cycle.
- flush_o  output  1  clear all pipeline registers this cycle.
- ex_mc_done_o  output  1  one-cycle pulse: multi-cycle result valid in EX this cycle.
- stall_cnt_o  output  CNT_W  saturating count of cycles with stall_o[0]==1.

Behaviour:
- States: RUN, MC_BUSY. Internal 8-bit down-counter mc_cnt.
- Reset (rst==0 at an edge) sets state RUN, mc_cnt 0, stall_cnt_o 0.
- While rst==0, all combinational outputs are forced to 0: stall_o=0, id_bubble_o=0, flush_o=0, ex_mc_done_o=0.
- Reset mid-MC_BUSY aborts the op; no done pulse is generated.
- Load-use hazard (lu), combinational: ex_is_load_i & ex_wreg_i & (ex_wd_i!=0) & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)). Register $0 never causes a hazard.
- Outputs are combinational from state, mc_cnt and inputs. Zero-latency decision in the same cycle.
- Priority is flush_i, then MC, then lu.
- RUN, flush_i=1:
  - flush_o=1, stall_o=0, id_bubble_o=0; remain RUN.
  - ex_mc_req_i is ignored that cycle.
- RUN, ex_mc_req_i=1:
  - stall_o=6'b001111; load mc_cnt=MC_LAT-1; go MC_BUSY.
  - lu is ignored, because a load and a multi-cycle op cannot share EX.
- RUN, lu=1:
  - stall_o=6'b000111, id_bubble_o=1; remain RUN.
  - The stall lasts exactly one cycle because the load advances to MEM, where the MEM forwarding path supplies data.
  - A back-to-back lu against a new EX instruction stalls again.
- RUN, otherwise: all outputs 0.
- MC_BUSY, flush_i=1:
  - flush_o=1, stall_o=0, no done pulse; mc_cnt<=0; go RUN.
- MC_BUSY, mc_cnt==1:
  - ex_mc_done_o=1, stall_o=0; go RUN.
- MC_BUSY, otherwise:
  - stall_o=6'b001111; mc_cnt<=mc_cnt-1.
  - ex_mc_req_i and lu are ignored.
- MC timing: request cycle T0. Stall is held T0..T0+MC_LAT-2; done pulses at T0+MC_LAT-1. Total EX occupancy is MC_LAT cycles.
- A new ex_mc_req_i in the cycle after done starts a fresh sequence.
- stall_cnt_o increments on each edge where stall_o[0]==1 and rst==1. It saturates at all-ones and never wraps.

Decomposition:
- Add to defines.vh:
  - stall vector constants `StallNone 6'b000000, `StallLoadUse 6'b000111, `StallMulti 6'b001111.
  - state encodings `CtrlRun, `CtrlMcBusy.
  - `StallBus 5:0.
- Reuse the existing `RegAddrBus and `ZeroWord.
- No sub-module: the counter and FSM are small enough to stay in one module.

Test Plan:
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 for 1 cycle -> stall_o=000111, id_bubble_o=1 that cycle only; stall_cnt_o=1.
- $0 exclusion: same as above with ex_wd=0, id_reg1_addr=0 -> stall_o=0, id_bubble_o=0.
- Multi-cycle, MC_LAT=8: ex_mc_req_i held high from T0 -> stall_o=001111 at T0..T6, ex_mc_done_o=1 at T7 with stall_o=0; stall_cnt_o=7.
- Flush mid-op: ex_mc_req_i at T0, flush_i=1 at T3 -> flush_o=1, stall_o=0 at T3, no done pulse; state RUN at T4 with ex_mc_req_i=0 -> all outputs 0.
- Reset mid-op: rst=0 at T2 of an MC sequence -> all outputs 0 during reset; stall_cnt_o=0 afterwards; next request restarts the full MC_LAT count.
- Priority/saturation: CNT_W=4, lu and flush_i together -> flush_o=1, id_bubble_o=0. Then 20 consecutive lu cycles -> stall_cnt_o saturates at 15.
